// File: rtl/noc_credit_pkg.sv
// Shared defaults for the per-VC credit counter and a helper for its width.
package noc_credit_pkg;

  localparam int DEFAULT_NUM_VC      = 4;
  localparam int DEFAULT_MAX_CREDITS = 4;

  // Bits needed to hold every count from 0 up to and including max_credits.
  function automatic int calc_cw(input int max_credits);
    return $clog2(max_credits + 1);
  endfunction

endpackage

// File: rtl/credit_counter_slice.sv
// One virtual channel: saturating credit count plus sticky over/underflow flags.
module credit_counter_slice import noc_credit_pkg::*; #(
  parameter int MAX_CREDITS = DEFAULT_MAX_CREDITS,
  parameter int CW          = calc_cw(MAX_CREDITS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          incr_i,
  input  logic          decr_i,
  input  logic          err_clr_i,
  output logic [CW-1:0] cnt_o,
  output logic          overflow_o,
  output logic          underflow_o
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_CREDITS);

  logic [CW-1:0] cnt_d, cnt_q;
  logic          ovf_d, ovf_q;
  logic          unf_d, unf_q;

  // Next count and flags; incr and decr together cancel, a new error beats a clear.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = err_clr_i ? 1'b0 : ovf_q;
    unf_d = err_clr_i ? 1'b0 : unf_q;
    if (incr_i && !decr_i) begin
      if (cnt_q == MAX_CNT) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + CW'(1);
    end else if (decr_i && !incr_i) begin
      if (cnt_q == '0) unf_d = 1'b1;
      else             cnt_d = cnt_q - CW'(1);
    end
  end

  // Registers; reset refills the channel to full credit and clears flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= MAX_CNT;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule

// File: rtl/credit_counter_mvc.sv
// Multi-VC credit counter: one independent slice per virtual channel.
module credit_counter_mvc import noc_credit_pkg::*; #(
  parameter int NUM_VC      = DEFAULT_NUM_VC,
  parameter int MAX_CREDITS = DEFAULT_MAX_CREDITS,
  localparam int CW         = $clog2(MAX_CREDITS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_VC-1:0]    incr_i,
  input  logic [NUM_VC-1:0]    decr_i,
  input  logic                 err_clr_i,
  output logic [NUM_VC-1:0]    credit_en_o,
  output logic [NUM_VC*CW-1:0] credit_cnt_o,
  output logic                 any_credit_o,
  output logic [NUM_VC-1:0]    overflow_o,
  output logic [NUM_VC-1:0]    underflow_o
);

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic [CW-1:0] cnt;

    credit_counter_slice #(
      .MAX_CREDITS (MAX_CREDITS),
      .CW          (CW)
    ) u_slice (
      .clk         (clk),
      .rst         (rst),
      .incr_i      (incr_i[v]),
      .decr_i      (decr_i[v]),
      .err_clr_i   (err_clr_i),
      .cnt_o       (cnt),
      .overflow_o  (overflow_o[v]),
      .underflow_o (underflow_o[v])
    );

    assign credit_cnt_o[v*CW +: CW] = cnt;
    assign credit_en_o[v]           = (cnt != '0);
  end

  assign any_credit_o = |credit_en_o;

endmodule

// File: tb/tb_credit_counter_mvc.sv
// Bench for credit_counter_mvc: directed vectors, random traffic, per-cycle model compare.
module tb_credit_counter_mvc;

  localparam int NV = 4;
  localparam int MC = 4;
  localparam int CW = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NV-1:0]     incr_i = '0;
  logic [NV-1:0]     decr_i = '0;
  logic              err_clr_i = 1'b0;
  logic [NV-1:0]     credit_en_o;
  logic [NV*CW-1:0]  credit_cnt_o;
  logic              any_credit_o;
  logic [NV-1:0]     overflow_o;
  logic [NV-1:0]     underflow_o;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  int cnt_m [NV];
  bit ovf_m [NV];
  bit unf_m [NV];

  credit_counter_mvc #(.NUM_VC(NV), .MAX_CREDITS(MC)) dut (
    .clk          (clk),
    .rst          (rst),
    .incr_i       (incr_i),
    .decr_i       (decr_i),
    .err_clr_i    (err_clr_i),
    .credit_en_o  (credit_en_o),
    .credit_cnt_o (credit_cnt_o),
    .any_credit_o (any_credit_o),
    .overflow_o   (overflow_o),
    .underflow_o  (underflow_o)
  );

  always #5 clk = ~clk;

  // Reference model: channel credits as plain integers, updated per rules each edge.
  always @(posedge clk) begin
    for (int v = 0; v < NV; v++) begin
      if (rst) begin
        cnt_m[v] = MC;
        ovf_m[v] = 0;
        unf_m[v] = 0;
      end else begin
        if (err_clr_i) begin
          ovf_m[v] = 0;
          unf_m[v] = 0;
        end
        if (incr_i[v] && !decr_i[v]) begin
          if (cnt_m[v] == MC) ovf_m[v] = 1;
          else cnt_m[v] = cnt_m[v] + 1;
        end else if (decr_i[v] && !incr_i[v]) begin
          if (cnt_m[v] == 0) unf_m[v] = 1;
          else cnt_m[v] = cnt_m[v] - 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare every DUT output against the model away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [NV*CW-1:0] e_cnt;
      logic [NV-1:0]    e_en, e_ovf, e_unf;
      e_cnt = '0;
      for (int v = 0; v < NV; v++) begin
        e_cnt[v*CW +: CW] = CW'(cnt_m[v]);
        e_en[v]  = (cnt_m[v] > 0);
        e_ovf[v] = ovf_m[v];
        e_unf[v] = unf_m[v];
      end
      chk("model_cnt", 32'(credit_cnt_o), 32'(e_cnt));
      chk("model_en", 32'(credit_en_o), 32'(e_en));
      chk("model_any", 32'(any_credit_o), 32'(e_en != '0));
      chk("model_ovf", 32'(overflow_o), 32'(e_ovf));
      chk("model_unf", 32'(underflow_o), 32'(e_unf));
    end
  end

  task automatic step(input logic [NV-1:0] inc, input logic [NV-1:0] dec,
                      input logic clr, input logic r);
    incr_i    = inc;
    decr_i    = dec;
    err_clr_i = clr;
    rst       = r;
    @(posedge clk);
    #1;
    incr_i    = '0;
    decr_i    = '0;
    err_clr_i = 1'b0;
    rst       = 1'b0;
  endtask

  function automatic logic [CW-1:0] fld(input int v);
    return credit_cnt_o[v*CW +: CW];
  endfunction

  initial begin
    int exp_drain [4];
    exp_drain = '{3, 2, 1, 0};

    // Reset
    step('0, '0, 0, 1);
    chk_en = 1'b1;
    chk("rst_cnt", 32'(credit_cnt_o), 32'h924);
    chk("rst_en", 32'(credit_en_o), 32'hF);
    chk("rst_any", 32'(any_credit_o), 32'h1);
    chk("rst_ovf", 32'(overflow_o), 32'h0);
    chk("rst_unf", 32'(underflow_o), 32'h0);

    // Drain VC2 and underflow it
    for (int i = 0; i < 4; i++) begin
      step(4'b0000, 4'b0100, 0, 0);
      chk("drain_vc2", 32'(fld(2)), 32'(exp_drain[i]));
    end
    chk("drain_en", 32'(credit_en_o), 32'b1011);
    step(4'b0000, 4'b0100, 0, 0);
    chk("unf_cnt2", 32'(fld(2)), 32'h0);
    chk("unf_flag", 32'(underflow_o), 32'b0100);

    // Simultaneous incr/decr at both ends
    for (int i = 0; i < 4; i++) step(4'b0000, 4'b0010, 0, 0);
    step(4'b0010, 4'b0010, 0, 0);
    chk("sim_vc1_cnt", 32'(fld(1)), 32'h0);
    chk("sim_vc1_unf", 32'(underflow_o), 32'b0100);
    step(4'b0001, 4'b0001, 0, 0);
    chk("sim_vc0_cnt", 32'(fld(0)), 32'h4);
    chk("sim_vc0_ovf", 32'(overflow_o), 32'h0);

    // Overflow, clear, clear vs new event
    step(4'b1000, 4'b0000, 0, 0);
    chk("ovf_cnt3", 32'(fld(3)), 32'h4);
    chk("ovf_flag", 32'(overflow_o), 32'b1000);
    step('0, '0, 1, 0);
    chk("clr_ovf", 32'(overflow_o), 32'h0);
    chk("clr_unf", 32'(underflow_o), 32'h0);
    step(4'b1000, 4'b0000, 1, 0);
    chk("set_wins", 32'(overflow_o), 32'b1000);

    // Build counts {0,1,2,3} then reset mid-operation
    step('0, '0, 0, 1);
    step(4'b0000, 4'b1111, 0, 0);
    step(4'b0000, 4'b0111, 0, 0);
    step(4'b0000, 4'b0011, 0, 0);
    step(4'b0000, 4'b0001, 0, 0);
    chk("mid_cnt", 32'(credit_cnt_o), 32'h688);
    step(4'b0000, 4'b1111, 0, 1);
    chk("mid_rst_cnt", 32'(credit_cnt_o), 32'h924);
    chk("mid_rst_ovf", 32'(overflow_o), 32'h0);
    chk("mid_rst_unf", 32'(underflow_o), 32'h0);

    // All channels empty
    for (int i = 0; i < 4; i++) step(4'b0000, 4'b1111, 0, 0);
    chk("empty_any", 32'(any_credit_o), 32'h0);
    chk("empty_en", 32'(credit_en_o), 32'h0);
    chk("empty_cnt", 32'(credit_cnt_o), 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 10000; i++) begin
      step(NV'($urandom), NV'($urandom), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 499) == 0));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/credit_counter_mvc.md
CREDIT_COUNTER_MVC -- requirements
Module: credit_counter_mvc

Interface
REQ-001 SHALL have parameter NUM_VC, default 4: number of virtual channels (1..16).
REQ-002 SHALL have parameter MAX_CREDITS, default 4: downstream buffer depth per VC (1..255).
REQ-003 SHALL derive localparam CW = $clog2(MAX_CREDITS+1): counter width.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 incr_i  input  NUM_VC  credit returned by downstream router, one bit per VC.
REQ-008 decr_i  input  NUM_VC  flit sent downstream on that VC, consumes one credit.
REQ-009 err_clr_i  input  1  clears sticky error flags.
REQ-010 credit_en_o  output  NUM_VC  VC holds at least one credit; sending permitted.
REQ-011 credit_cnt_o  output  NUM_VC*CW  packed per-VC credit counts, VC0 in LSBs.
REQ-012 any_credit_o  output  1  OR of credit_en_o.
REQ-013 overflow_o  output  NUM_VC  sticky: incr_i seen while VC count == MAX_CREDITS.
REQ-014 underflow_o  output  NUM_VC  sticky: decr_i seen while VC count == 0.

Function
REQ-015 Each VC SHALL keep an independent CW-bit count register; VCs never interact.
REQ-016 Count update SHALL take effect on the rising edge after the inputs; outputs reflect the registered count (1-cycle latency).
REQ-017 incr_i only, count < MAX_CREDITS: count SHALL increment by 1.
REQ-018 decr_i only, count > 0: count SHALL decrement by 1.
REQ-019 incr_i and decr_i together: count SHALL be unchanged, at every value including 0 and MAX_CREDITS; no error flag set.
REQ-020 incr_i only at count == MAX_CREDITS: count SHALL hold (saturate), overflow_o[v] SHALL set next cycle.
REQ-021 decr_i only at count == 0: count SHALL hold at 0 (no wrap), underflow_o[v] SHALL set next cycle.
REQ-022 credit_en_o[v] SHALL equal (count[v] != 0), combinational from the register, no input-to-output path.
REQ-023 any_credit_o SHALL be the OR of all credit_en_o bits.
REQ-024 Error flags SHALL remain set until err_clr_i or rst; err_clr_i SHALL clear all flags next cycle.
REQ-025 err_clr_i coincident with a new error event: the set SHALL win (flag reads 1 next cycle).
REQ-026 No state machine beyond the counters; behaviour SHALL be identical for NUM_VC = 1.

Reset
REQ-027 On rst, every count SHALL load MAX_CREDITS (downstream buffers empty), so credit_en_o = all ones, any_credit_o = 1.
REQ-028 On rst, overflow_o and underflow_o SHALL clear to 0.
REQ-029 rst SHALL override incr_i, decr_i, err_clr_i in the same cycle, including mid-operation.

Structure
REQ-030 Package noc_credit_pkg SHALL hold default NUM_VC, MAX_CREDITS and a function computing CW.
REQ-031 One sub-module credit_counter_slice SHALL implement a single VC (count, saturation, sticky flags), instantiated NUM_VC times via generate.
REQ-032 Top level SHALL contain only the generate loop, output packing and any_credit_o.

Verification (NUM_VC=4, MAX_CREDITS=4, CW=3)
REQ-033 Reset: assert rst 1 cycle -> credit_cnt_o = 12'h924 (4 per VC), credit_en_o = 4'b1111, flags 0.
REQ-034 Drain VC2: decr_i=4'b0100 for 4 cycles -> cnt[2] 3,2,1,0; credit_en_o = 4'b1011; fifth decr -> cnt[2] stays 0, underflow_o = 4'b0100.
REQ-035 Simultaneous: VC1 at 0, incr_i=decr_i=4'b0010 -> cnt[1] stays 0, no underflow; VC0 at 4 same stimulus -> stays 4, no overflow.
REQ-036 Overflow: VC3 at 4, incr_i=4'b1000 -> cnt[3] stays 4, overflow_o = 4'b1000; err_clr_i 1 cycle -> 0; err_clr_i with another incr -> stays 1.
REQ-037 Reset mid-operation: counts {0,1,2,3}, rst with decr_i=4'b1111 -> all counts 4, flags 0 next cycle.
REQ-038 Random incr/decr 10k cycles against a scoreboard model; all VCs at 0 -> any_credit_o = 0.
